// File: rtl/fifo_controller.sv
// fifo_controller: pointer/flag sequencer for a dual-port RAM FIFO with valid/ready push and pop sides.
// Define FIFO_CONTROLLER_ERROR_FLAGS_EN to add sticky overflow/underflow flags with error_clear.
module fifo_controller #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDRESS_WIDTH      = 4,
  parameter int ALMOST_FULL_LEVEL  = 2**ADDRESS_WIDTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     write_valid,
  output logic                     write_ready,
  output logic                     read_valid,
  input  logic                     read_ready,
  output logic                     ram_write_increment,
  output logic                     ram_full,
  output logic [ADDRESS_WIDTH-1:0] ram_write_address,
  output logic [ADDRESS_WIDTH-1:0] ram_read_address,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH:0]   fill_level
`ifdef FIFO_CONTROLLER_ERROR_FLAGS_EN
  ,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     error_clear
`endif
);
  localparam logic [ADDRESS_WIDTH:0] AF_LEVEL = ALMOST_FULL_LEVEL[ADDRESS_WIDTH:0];
  localparam logic [ADDRESS_WIDTH:0] AE_LEVEL = ALMOST_EMPTY_LEVEL[ADDRESS_WIDTH:0];
  // Data never passes through the controller; the width only has to be legal for the RAM.
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("DATA_WIDTH must be at least 1");
  end
  logic [ADDRESS_WIDTH:0] r_wr_ptr;
  logic [ADDRESS_WIDTH:0] r_rd_ptr;
  logic [ADDRESS_WIDTH:0] r_fill_level;
  logic                   w_push;
  logic                   w_pop;
  assign empty               = r_wr_ptr == r_rd_ptr;
  assign full                = (r_wr_ptr[ADDRESS_WIDTH-1:0] == r_rd_ptr[ADDRESS_WIDTH-1:0]) &&
                               (r_wr_ptr[ADDRESS_WIDTH] != r_rd_ptr[ADDRESS_WIDTH]);
  assign write_ready         = !full;
  assign read_valid          = !empty;
  assign w_push              = write_valid && !full;
  assign w_pop               = read_valid && read_ready;
  assign ram_write_increment = write_valid;
  assign ram_full            = full;
  assign ram_write_address   = r_wr_ptr[ADDRESS_WIDTH-1:0];
  assign ram_read_address    = r_rd_ptr[ADDRESS_WIDTH-1:0];
  assign fill_level          = r_fill_level;
  assign almost_full         = r_fill_level >= AF_LEVEL;
  assign almost_empty        = r_fill_level <= AE_LEVEL;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill_level <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_fill_level <= (w_push && !w_pop) ? r_fill_level + 1'b1 :
                      (w_pop && !w_push) ? r_fill_level - 1'b1 : r_fill_level;
    end
  end
`ifdef FIFO_CONTROLLER_ERROR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (error_clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write_valid && full) r_overflow <= 1'b1;
      if (read_ready && empty) r_underflow <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_controller.sv
// tb_fifo_controller: queue-based reference model with directed test-plan sequences and random traffic.
module tb_fifo_controller;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          write_valid = 1'b0;
  logic          read_ready = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic          write_ready, read_valid, ram_write_increment, ram_full, full, empty;
  logic          almost_full, almost_empty;
  logic [AW-1:0] ram_write_address, ram_read_address;
  logic [AW:0]   fill_level;
`ifdef FIFO_CONTROLLER_ERROR_FLAGS_EN
  logic          overflow, underflow;
  logic          error_clear = 1'b0;
  logic          m_ov, m_un;
`endif
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q[$];
  int unsigned   wr_cnt, rd_cnt;

  fifo_controller #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .write_valid(write_valid), .write_ready(write_ready),
    .read_valid(read_valid), .read_ready(read_ready),
    .ram_write_increment(ram_write_increment), .ram_full(ram_full),
    .ram_write_address(ram_write_address), .ram_read_address(ram_read_address),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .fill_level(fill_level)
`ifdef FIFO_CONTROLLER_ERROR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow), .error_clear(error_clear)
`endif
  );

  always #5 clock = ~clock;

  // RAM model: registered write gated by its own full pin, combinational read.
  always @(posedge clock)
    if (ram_write_increment && !ram_full) mem[ram_write_address] <= write_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO is a queue; addresses are total transfer counts modulo DEPTH.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      wr_cnt = 0;
      rd_cnt = 0;
`ifdef FIFO_CONTROLLER_ERROR_FLAGS_EN
      m_ov = 1'b0;
      m_un = 1'b0;
`endif
    end else begin
      automatic bit was_full = q.size() == DEPTH;
      automatic bit was_empty = q.size() == 0;
`ifdef FIFO_CONTROLLER_ERROR_FLAGS_EN
      if (error_clear) begin
        m_ov = 1'b0;
        m_un = 1'b0;
      end else begin
        if (write_valid && was_full) m_ov = 1'b1;
        if (read_ready && was_empty) m_un = 1'b1;
      end
`endif
      if (read_ready && !was_empty) begin
        void'(q.pop_front());
        rd_cnt++;
      end
      if (write_valid && !was_full) begin
        q.push_back(write_data);
        wr_cnt++;
      end
    end
  end

  always @(negedge clock) begin
    chk("fill_level", fill_level, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("write_ready", write_ready, q.size() != DEPTH);
    chk("read_valid", read_valid, q.size() != 0);
    chk("almost_full", almost_full, q.size() >= DEPTH - 2);
    chk("almost_empty", almost_empty, q.size() <= 2);
    chk("ram_full", ram_full, q.size() == DEPTH);
    chk("ram_write_increment", ram_write_increment, write_valid);
    chk("ram_write_address", ram_write_address, wr_cnt % DEPTH);
    chk("ram_read_address", ram_read_address, rd_cnt % DEPTH);
    if (q.size() != 0) chk("head_data", mem[ram_read_address], q[0]);
`ifdef FIFO_CONTROLLER_ERROR_FLAGS_EN
    chk("overflow", overflow, m_ov);
    chk("underflow", underflow, m_un);
`endif
  end

  task automatic step(input logic wv, input logic rr, input logic [DW-1:0] d);
    write_valid = wv;
    read_ready = rr;
    write_data = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_write_ready", write_ready, 1);
    chk("rst_read_valid", read_valid, 0);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_almost_full", almost_full, 0);
    reset_n = 1'b1;
    step(0, 0, 0);
    step(1, 0, 32'hA5A5_0001);
    chk("first_read_valid", read_valid, 1);
    chk("first_fill", fill_level, 1);
    chk("first_raddr", ram_read_address, 0);
    chk("first_empty", empty, 0);
    chk("first_almost_empty", almost_empty, 1);
    chk("first_data", mem[ram_read_address], 32'hA5A5_0001);
    for (int i = 2; i <= DEPTH; i++) begin
      step(1, 0, 32'h1000 + i);
      if (i == 13) chk("af_at_13", almost_full, 0);
      if (i == 14) chk("af_at_14", almost_full, 1);
    end
    chk("full_flag", full, 1);
    chk("full_write_ready", write_ready, 0);
    chk("full_fill", fill_level, 16);
    step(1, 0, 32'hDEAD_BEEF);
    chk("over_push_fill", fill_level, 16);
    chk("over_push_waddr", ram_write_address, 0);
    chk("over_push_head", mem[0], 32'hA5A5_0001);
    step(1, 1, 32'hBAD0_0001);
    chk("full_pushpop_fill", fill_level, 15);
    chk("full_pushpop_raddr", ram_read_address, 1);
    chk("full_pushpop_waddr", ram_write_address, 0);
    step(1, 0, 32'h2000_0000);
    chk("refill_fill", fill_level, 16);
    for (int i = 0; i < 13; i++) step(0, 1, 0);
    chk("drained_fill", fill_level, 3);
    for (int i = 0; i < 40; i++) begin
      step(1, 1, $urandom);
      chk("stream_fill", fill_level, 3);
    end
    for (int i = 0; i < 6; i++) step(1, 0, 32'h3000 + i);
    chk("pre_reset_fill", fill_level, 9);
    write_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_empty", empty, 1);
    chk("async_rst_fill", fill_level, 0);
    chk("async_rst_waddr", ram_write_address, 0);
    chk("async_rst_raddr", ram_read_address, 0);
    step(0, 0, 0);
    reset_n = 1'b1;
    step(0, 0, 0);
    step(1, 0, 32'h5A5A_0042);
    chk("post_rst_mem0", mem[0], 32'h5A5A_0042);
    chk("post_rst_waddr", ram_write_address, 1);
    step(0, 1, 0);
`ifdef FIFO_CONTROLLER_ERROR_FLAGS_EN
    step(0, 1, 0);
    chk("underflow_set", underflow, 1);
    step(0, 0, 0);
    chk("underflow_hold", underflow, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 0, $urandom);
    chk("overflow_clear_pre", overflow, 0);
    step(1, 0, 0);
    chk("overflow_set", overflow, 1);
    error_clear = 1'b1;
    step(1, 0, 0);
    error_clear = 1'b0;
    chk("clear_overflow", overflow, 0);
    chk("clear_underflow", underflow, 0);
`endif
    for (int i = 0; i < 600; i++) begin
      automatic int mode = (i / 150) % 4;
      automatic int wp = mode == 0 ? 80 : mode == 1 ? 30 : 60;
      automatic int rp = mode == 0 ? 30 : mode == 1 ? 80 : 60;
`ifdef FIFO_CONTROLLER_ERROR_FLAGS_EN
      error_clear = $urandom_range(0, 19) == 0;
`endif
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
      end
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, $urandom);
    end
    step(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
